// File: rtl/mux16to1.sv
// rtl/mux16to1.sv - 16:1 bit mux with a registered output stage
// Optional register-stage freeze port enabled by MUX16TO1_HOLD_EN.
module mux16to1 (
    input  logic        clk,
    input  logic        rst,
`ifdef MUX16TO1_HOLD_EN
    input  logic        hold,
`endif
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out,
    output logic        out_q,
    output logic [3:0]  sel_q,
    output logic        out_vld
);

    logic       load_en;
    logic       out_d;
    logic [3:0] sel_d;
    logic       vld_d;

    // Full binary decode; out never depends on clk or rst.
    assign out = in[sel];

`ifdef MUX16TO1_HOLD_EN
    assign load_en = ~hold;
`else
    assign load_en = 1'b1;
`endif

    always_comb begin
        out_d = out_q;
        sel_d = sel_q;
        vld_d = out_vld;
        if (rst) begin
            out_d = 1'b0;
            sel_d = 4'h0;
            vld_d = 1'b0;
        end else if (load_en) begin
            out_d = out;
            sel_d = sel;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        out_q   <= out_d;
        sel_q   <= sel_d;
        out_vld <= vld_d;
    end

endmodule

// File: tb/tb_mux16to1.sv
// tb/tb_mux16to1.sv - self-checking bench for mux16to1
// Build with MUX16TO1_HOLD_EN defined to exercise the hold port as well.
module tb_mux16to1;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [15:0] in;
    logic [3:0]  sel;
    logic        out;
    logic        out_q;
    logic [3:0]  sel_q;
    logic        out_vld;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MUX16TO1_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    // Reference state of the register stage
    logic        m_out_q;
    logic [3:0]  m_sel_q;
    logic        m_vld;

    mux16to1 dut (
        .clk     (clk),
        .rst     (rst),
`ifdef MUX16TO1_HOLD_EN
        .hold    (hold),
`endif
        .in      (in),
        .sel     (sel),
        .out     (out),
        .out_q   (out_q),
        .sel_q   (sel_q),
        .out_vld (out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pick(input logic [15:0] v, input logic [3:0] s);
        return ((v >> s) & 16'h1) != 16'h0;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive away from the edge, check out combinationally, then the edge result.
    task automatic step(input logic r, input logic h, input logic [15:0] v, input logic [3:0] s,
                        input bit chk_regs);
        @(negedge clk);
        rst  = r;
        hold = h;
        in   = v;
        sel  = s;
        #1;
        check("out_comb", {15'b0, out}, {15'b0, pick(v, s)});
        @(posedge clk);
        if (r) begin
            m_out_q = 1'b0;
            m_sel_q = 4'h0;
            m_vld   = 1'b0;
        end else if (!(HOLD_EN && h)) begin
            m_out_q = pick(v, s);
            m_sel_q = s;
            m_vld   = 1'b1;
        end
        #1;
        if (chk_regs) begin
            check("out_q",   {15'b0, out_q},   {15'b0, m_out_q});
            check("sel_q",   {12'b0, sel_q},   {12'b0, m_sel_q});
            check("out_vld", {15'b0, out_vld}, {15'b0, m_vld});
        end
    endtask

    logic [15:0] pat;
    logic [3:0]  sel_list [6];
    logic        exp_list [6];

    initial begin
        rst = 1'b1; hold = 1'b0; in = 16'h0; sel = 4'h0;
        pat = 16'b1010010111110000;
        sel_list = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd10, 4'd15};
        exp_list = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        step(1'b1, 1'b0, pat, 4'd5, 1'b1);
        check("rst_out_q",   {15'b0, out_q},   16'h0);
        check("rst_out_vld", {15'b0, out_vld}, 16'h0);
        check("rst_sel_q",   {12'b0, sel_q},   16'h0);

        // Fixed pattern against hand-computed values
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, pat, sel_list[i], 1'b1);
            check("pat_out", {15'b0, out}, {15'b0, exp_list[i]});
            check("pat_out_q", {15'b0, out_q}, {15'b0, exp_list[i]});
        end
        step(1'b0, 1'b0, pat, 4'd4, 1'b1);
        check("pat_sel4", {15'b0, out}, 16'h1);
        step(1'b0, 1'b0, pat, 4'd8, 1'b1);
        check("pat_sel8", {15'b0, out}, 16'h1);

        // Walking one across every select value
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                step(1'b0, 1'b0, 16'h1 << k, 4'(s), 1'b1);
                check("walk1", {15'b0, out}, {15'b0, (s == k)});
            end
        end

        // Reset for two edges, then release with sel=10
        step(1'b1, 1'b0, pat, 4'd10, 1'b1);
        check("rst_mid_out_keeps", {15'b0, out}, 16'h1);
        step(1'b1, 1'b0, pat, 4'd10, 1'b1);
        check("rst2_out_q",   {15'b0, out_q},   16'h0);
        check("rst2_out_vld", {15'b0, out_vld}, 16'h0);
        step(1'b0, 1'b0, pat, 4'd10, 1'b1);
        check("rel_out_q",   {15'b0, out_q},   16'h1);
        check("rel_sel_q",   {12'b0, sel_q},   16'ha);
        check("rel_out_vld", {15'b0, out_vld}, 16'h1);

        // Combinational path reacts without any clock edge
        @(negedge clk);
        in = 16'h0001; sel = 4'd0; #1;
        check("async_in", {15'b0, out}, 16'h1);
        sel = 4'd3; #1;
        check("async_sel", {15'b0, out}, 16'h0);
        in = 16'h0008; #1;
        check("async_in2", {15'b0, out}, 16'h1);

`ifdef MUX16TO1_HOLD_EN
        step(1'b0, 1'b0, pat, 4'd10, 1'b1);
        check("hold_pre_q", {15'b0, out_q}, 16'h1);
        step(1'b0, 1'b1, pat, 4'd0, 1'b1);
        check("hold_out_live", {15'b0, out}, 16'h0);
        check("hold_out_q", {15'b0, out_q}, 16'h1);
        check("hold_sel_q", {12'b0, sel_q}, 16'ha);
        step(1'b0, 1'b1, pat, 4'd0, 1'b1);
        check("hold2_out_q", {15'b0, out_q}, 16'h1);
        step(1'b0, 1'b0, pat, 4'd0, 1'b1);
        check("unhold_out_q", {15'b0, out_q}, 16'h0);
        check("unhold_sel_q", {12'b0, sel_q}, 16'h0);
        step(1'b0, 1'b0, pat, 4'd10, 1'b1);
        step(1'b1, 1'b1, pat, 4'd10, 1'b1);
        check("rst_over_hold_q",   {15'b0, out_q},   16'h0);
        check("rst_over_hold_vld", {15'b0, out_vld}, 16'h0);
`endif

        // Randomized traffic with occasional reset and hold
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
